// File: rtl/rv32_mod_data_mem_responder_if.sv
// rv32_mod_data_mem_responder_if: hart data bus (req/wr/be/addr/wdata from master; rdata/ack/err from slave)
interface rv32_mod_data_mem_responder_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_data_i;
  logic [31:0] data_data_o;
  logic        data_ack;
  logic        data_err;
  modport master (output data_req, data_wr, data_be, data_addr, data_data_i, input data_data_o, data_ack, data_err);
  modport slave (input data_req, data_wr, data_be, data_addr, data_data_i, output data_data_o, data_ack, data_err);
endinterface

// File: rtl/rv32_mod_data_mem_responder.sv
// rv32_mod_data_mem_responder: byte-enabled word SRAM bus responder with wait states and range/be errors (clk, reset, bus slave modport)
module rv32_mod_data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input logic clk,
  input logic reset,
  rv32_mod_data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] idx_q, idx;
  logic wr_q, err_q, wr, err, err_in, ack_n, err_n, we, ack_q, err_o_q, cap;
  logic [3:0] be_q, be;
  logic [31:0] wd_q, wd, off, rd_n, rd_q;
  logic [31:0] mem [DEPTH_WORDS];
  assign off = bus.data_addr - BASE_ADDR;
  assign err_in = off >= SPAN || bus.data_be == 4'b0000;
  assign cap = state == S_IDLE;
  assign idx = cap ? off[AW+1:2] : idx_q;
  assign wr = cap ? bus.data_wr : wr_q;
  assign be = cap ? bus.data_be : be_q;
  assign wd = cap ? bus.data_data_i : wd_q;
  assign err = cap ? err_in : err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      ack_q <= 1'b0;
      err_o_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ack_q <= ack_n;
      err_o_q <= err_n;
      rd_q <= rd_n;
    end
    if (cap && bus.data_req) begin
      idx_q <= idx;
      wr_q <= wr;
      be_q <= be;
      wd_q <= wd;
      err_q <= err;
    end
  end
  always_comb begin
    state_n = state == S_IDLE ? (bus.data_req ? (WAIT_STATES == 0 ? S_RESP : S_WAIT) : S_IDLE)
            : state == S_WAIT ? (cnt == 4'd0 ? S_RESP : S_WAIT) : S_IDLE;
    cnt_n = state == S_IDLE ? 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0)
          : (state == S_WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  always_comb begin
    ack_n = state_n == S_RESP && !err;
    err_n = state_n == S_RESP && err;
    we = ack_n && wr;
    rd_n = (ack_n && !wr) ? mem[idx] : '0;
  end
  always_ff @(posedge clk)
    if (!reset && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  assign bus.data_ack = ack_q;
  assign bus.data_err = err_o_q;
  assign bus.data_data_o = rd_q;
endmodule

// File: doc/rv32_mod_data_mem_responder.md
Name: rv32_mod_data_mem_responder

Overview:
- Bus responder (slave end) of the hart data interface driven by the load/store unit: data_req/data_wr/data_be/data_addr/write data in, data_ack/data_err/read data out.
- Backs the bus with a word-organised, byte-enabled SRAM model, with programmable wait states and address-range/byte-enable error detection.
- Sits on the data port as on-chip data RAM, and is the standard memory model for hart-level benches.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0, extra cycles before the response (0..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_req  input  1  request valid; held high by the initiator until data_ack or data_err.
- data_wr  input  1  1 = store, 0 = load; stable while data_req is high.
- data_be  input  4  byte lane enables, bit i = bits [8i+7:8i].
- data_addr  input  32  word-aligned byte address; bits [1:0] ignored.
- data_data_i  input  32  store data, lane-aligned.
- data_data_o  output  32  load data; valid only in the data_ack cycle.
- data_ack  output  1  one-cycle pulse: access completed.
- data_err  output  1  one-cycle pulse: access rejected.

Behaviour:
- Single clock clk; reset is synchronous and active-high. While reset is high at an edge: state goes to IDLE, data_ack=0, data_err=0, data_data_o=0, wait counter=0. Memory contents are not reset.
- All outputs are registered. No combinational path runs from inputs to outputs.
- FSM states:
  - IDLE: if data_req=1, capture addr[31:2], wr, be and data_data_i, and evaluate the error condition. If WAIT_STATES=0, go to RESP. Otherwise load cnt=WAIT_STATES-1 and go to WAIT.
  - WAIT: if cnt=0, go to RESP; else decrement cnt. data_req is not re-sampled. Dropping data_req here is a protocol violation; the access still completes.
  - RESP: data_ack or data_err is high for exactly this cycle. Next state is always IDLE.
- Latency: request first seen high in IDLE at edge N; response is visible in cycle N+1+WAIT_STATES.
- A request held high through the response cycle is not re-accepted. Back-to-back throughput is one access per 2+WAIT_STATES cycles.
- Error condition (decided at capture):
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4), or
  - data_be == 4'b0000.
  - On error: data_err=1, data_ack=0, data_data_o=0, no memory write.
- Word index = (addr - BASE_ADDR) >> 2, taking the low log2(DEPTH_WORDS) bits.
- Store:
  - Enabled lanes of the captured data are written at the edge entering RESP; disabled lanes are unchanged.
  - The write is visible to any later load.
  - Any non-zero be pattern is accepted, including non-contiguous ones.
- Load:
  - data_data_o = the full 32-bit word at the index, ignoring be. The initiator performs lane extraction and sign extension.
  - data_data_o is 0 in every non-ack cycle.
- data_ack and data_err are never high together and never high in two consecutive cycles.
- Reset in WAIT: the pending access is dropped, with no write and no response. Reset in the RESP cycle: the write already committed stays; outputs clear next cycle.
- Changes to data_addr/data_wr/data_be/data_data_i after capture have no effect on the in-flight access.

Test Plan:
- WAIT_STATES=0, DEPTH_WORDS=1024, BASE_ADDR=0:
  - Store 32'hDEAD_BEEF to 0x10 with be=1111, then load 0x10 → ack one cycle after each req edge; load returns 32'hDEAD_BEEF; data_err never high.
  - Word 0x20 = 32'h1122_3344; store be=0100, data 32'h00AB_0000; load 0x20 → 32'h11AB_3344. Store be=1001, data 32'hFF00_00EE → 32'hFFAB_33EE.
  - Load 0x1000 (first out-of-range word), and store to 0x8 with be=0000 → data_err pulse, data_ack=0, data_data_o=0; word 0x8 unchanged.
  - Hold data_req high across 3 loads of distinct addresses, changing addr the cycle after each ack → exactly 3 ack pulses, spaced 2 cycles apart, each with the correct data.
- WAIT_STATES=3: load → ack exactly 4 cycles after capture. Assert reset in the second WAIT cycle of a store to 0x40 → no ack or err; word 0x40 unchanged; the next access behaves normally.
- BASE_ADDR=32'h8000_0000: load 32'h7FFF_FFFC → err; load 32'h8000_0000 → ack with word 0 contents.
